trail_collision_scanner: RTL

// Sequential reader of the packed trail arrays produced by the trail writer.
// On each start pulse it snapshots the trail and pig bounding box, then walks
// the trail one point per clock and reports whether the pig overlaps any

---
 rtl/trail_collision_scanner_if.sv | 38 +++
 rtl/trail_collision_scanner.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/trail_collision_scanner_if.sv
// Bundle of signals between the scan requester and trail_collision_scanner.
//   master : drives start, the packed trail arrays and the pig bounding box;
//            observes busy/done/hit/hit_index.
//   slave  : the scanner side of the same signals.
// Signals:
//   start                  scan request (sampled only when the scanner is idle)
//   trailX, trailY         packed cell coordinates, entry i = [BIT_WIDTH*i +: BIT_WIDTH]
//   pigX/pigX_end          pig left/right edge in pixels
//   pigY/pigY_end          pig top/bottom edge in pixels
//   busy, done, hit,       scanner status and result
//   hit_index
interface trail_collision_scanner_if #(
  parameter int TRAIL_POINTS = 16,
  parameter int BIT_WIDTH    = 5,
  parameter int IDX_W        = 4
) ();
  logic                              start;
  logic [TRAIL_POINTS*BIT_WIDTH-1:0] trailX;
  logic [TRAIL_POINTS*BIT_WIDTH-1:0] trailY;
  logic [9:0]                        pigX;
  logic [9:0]                        pigX_end;
  logic [9:0]                        pigY;
  logic [9:0]                        pigY_end;
  logic                              busy;
  logic                              done;
  logic                              hit;
  logic [IDX_W-1:0]                  hit_index;

  modport master (
    output start, trailX, trailY, pigX, pigX_end, pigY, pigY_end,
    input  busy, done, hit, hit_index
  );

  modport slave (
    input  start, trailX, trailY, pigX, pigX_end, pigY, pigY_end,
    output busy, done, hit, hit_index
  );
endinterface

// File: rtl/trail_collision_scanner.sv
// Sequential trail/pig overlap scanner.
// On an accepted start the trail arrays and pig box are snapshotted, then one
// trail entry is tested per clock. The scan exits early on the first
// overlapping entry, or after the last entry, and pulses done for one cycle.
// Ports:
//   clk  system clock
//   rst  synchronous reset, active-high (aborts a running scan, no done pulse)
//   bus  trail_collision_scanner_if.slave: start, trailX/trailY, pig box in;
//        busy, done, hit, hit_index out
module trail_collision_scanner #(
  parameter int TRAIL_POINTS = 16,
  parameter int BIT_WIDTH    = 5,
  parameter int TRAIL_WIDTH  = 20,
  parameter int IDX_W        = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  trail_collision_scanner_if.slave    bus
);

  localparam logic [BIT_WIDTH-1:0] EMPTY_CELL = '1;
  localparam logic [10:0]          CELL_PX    = 11'(TRAIL_WIDTH);
  localparam logic [IDX_W-1:0]     LAST_IDX   = IDX_W'(TRAIL_POINTS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  // Left/top pixel of a cell; 11 bits holds 31*TRAIL_WIDTH+TRAIL_WIDTH.
  function automatic logic [10:0] cell_px(input logic [BIT_WIDTH-1:0] c);
    return 11'(c) * CELL_PX;
  endfunction

  // One-axis overlap between pig span [lo,hi] and cell span [c, c+W].
  // Strict compares: touching an edge is not an overlap. The third term
  // catches a pig that fully covers the cell.
  function automatic logic axis_overlap(input logic [9:0]  lo,
                                        input logic [9:0]  hi,
                                        input logic [10:0] c);
    logic [10:0] lo_w;
    logic [10:0] hi_w;
    logic [10:0] c_end;
    lo_w  = {1'b0, lo};
    hi_w  = {1'b0, hi};
    c_end = c + CELL_PX;
    return ((lo_w > c) && (lo_w < c_end)) ||
           ((hi_w > c) && (hi_w < c_end)) ||
           ((lo_w <= c) && (hi_w >= c_end));
  endfunction

  state_t                            state_q, state_d;
  logic [IDX_W-1:0]                  idx_q, idx_d;
  logic                              hit_q, hit_d;
  logic [IDX_W-1:0]                  hit_index_q, hit_index_d;

  logic [TRAIL_POINTS*BIT_WIDTH-1:0] snap_x_q, snap_x_d;
  logic [TRAIL_POINTS*BIT_WIDTH-1:0] snap_y_q, snap_y_d;
  logic [9:0]                        pig_x_q, pig_x_d;
  logic [9:0]                        pig_x_end_q, pig_x_end_d;
  logic [9:0]                        pig_y_q, pig_y_d;
  logic [9:0]                        pig_y_end_q, pig_y_end_d;

  logic [BIT_WIDTH-1:0]              cur_x;
  logic [BIT_WIDTH-1:0]              cur_y;
  logic                              hit_i;

  // Entry under test this cycle, taken from the snapshot only.
  always_comb begin
    cur_x = snap_x_q[int'(idx_q)*BIT_WIDTH +: BIT_WIDTH];
    cur_y = snap_y_q[int'(idx_q)*BIT_WIDTH +: BIT_WIDTH];
    hit_i = (cur_x != EMPTY_CELL) && (cur_y != EMPTY_CELL) &&
            axis_overlap(pig_x_q, pig_x_end_q, cell_px(cur_x)) &&
            axis_overlap(pig_y_q, pig_y_end_q, cell_px(cur_y));
  end

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    hit_d       = hit_q;
    hit_index_d = hit_index_q;
    snap_x_d    = snap_x_q;
    snap_y_d    = snap_y_q;
    pig_x_d     = pig_x_q;
    pig_x_end_d = pig_x_end_q;
    pig_y_d     = pig_y_q;
    pig_y_end_d = pig_y_end_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start) begin
          snap_x_d    = bus.trailX;
          snap_y_d    = bus.trailY;
          pig_x_d     = bus.pigX;
          pig_x_end_d = bus.pigX_end;
          pig_y_d     = bus.pigY;
          pig_y_end_d = bus.pigY_end;
          idx_d       = '0;
          hit_d       = 1'b0;
          hit_index_d = '0;
          state_d     = SCAN;
        end
      end
      SCAN: begin
        if (hit_i) begin
          hit_d       = 1'b1;
          hit_index_d = idx_q;
          state_d     = DONE;
        end else if (idx_q == LAST_IDX) begin
          state_d     = DONE;
        end else begin
          idx_d       = idx_q + IDX_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control state: reset applies here only.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      hit_q       <= 1'b0;
      hit_index_q <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      hit_q       <= hit_d;
      hit_index_q <= hit_index_d;
    end
  end

  // Snapshot: only meaningful after an accepted start, so no reset.
  always_ff @(posedge clk) begin
    snap_x_q    <= snap_x_d;
    snap_y_q    <= snap_y_d;
    pig_x_q     <= pig_x_d;
    pig_x_end_q <= pig_x_end_d;
    pig_y_q     <= pig_y_d;
    pig_y_end_q <= pig_y_end_d;
  end

  assign bus.busy      = (state_q != IDLE);
  assign bus.done      = (state_q == DONE);
  assign bus.hit       = hit_q;
  assign bus.hit_index = hit_index_q;

endmodule
